// File: rtl/phase_sequencer.sv
// ----------------------------------------------------------------------------
// phase_sequencer
//
// Layer-phase sequencer for the CNN control unit. After IDLE (state 0) it
// steps through phases 1..NUM_PHASES and repeats that loop a programmed
// number of times. A phase ends on a manual advance pulse, or automatically
// once it has lasted its programmed number of cycles (when auto_en is high).
// Every output is registered.
//
// Ports
//   clk            in   system clock, rising edge
//   rstn           in   asynchronous active-low reset
//   start          in   begin a sequence (only sampled in IDLE)
//   abort          in   return to IDLE without done; highest priority
//   advance        in   manual step to the next phase
//   auto_en        in   enable length-based automatic advance
//   cfg_len        in   per-phase lengths, phase k at [(k-1)*CNT_W +: CNT_W]
//   cfg_iters      in   number of full phase loops
//   current_state  out  0 = IDLE, k = phase k
//   state_update   out  high on the first cycle of every new state value
//   phase_cnt      out  cycles spent in the current phase (0-based, saturating)
//   iter_cnt       out  current loop index (0-based)
//   busy           out  high while current_state != 0
//   done           out  one-cycle pulse on normal completion
// ----------------------------------------------------------------------------
module phase_sequencer #(
  parameter int NUM_PHASES = 3,
  parameter int STATE_W    = 2,
  parameter int CNT_W      = 16,
  parameter int ITER_W     = 8
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        start,
  input  logic                        abort,
  input  logic                        advance,
  input  logic                        auto_en,
  input  logic [NUM_PHASES*CNT_W-1:0] cfg_len,
  input  logic [ITER_W-1:0]           cfg_iters,
  output logic [STATE_W-1:0]          current_state,
  output logic                        state_update,
  output logic [CNT_W-1:0]            phase_cnt,
  output logic [ITER_W-1:0]           iter_cnt,
  output logic                        busy,
  output logic                        done
);

  localparam logic [STATE_W-1:0] IDLE       = '0;
  localparam logic [STATE_W-1:0] FIRST      = STATE_W'(1);
  localparam logic [STATE_W-1:0] LAST_PHASE = STATE_W'(NUM_PHASES);

  logic [STATE_W-1:0] state_q,  state_d;
  logic [CNT_W-1:0]   pcnt_q,   pcnt_d;
  logic [ITER_W-1:0]  iter_q,   iter_d;
  logic               busy_q,   busy_d;
  logic               done_q,   done_d;
  logic               upd_q,    upd_d;
  logic [ITER_W-1:0]  iters_q,  iters_d;
  logic [CNT_W-1:0]   len_q     [NUM_PHASES];
  logic [CNT_W-1:0]   len_d     [NUM_PHASES];
  logic [CNT_W-1:0]   len_eff   [NUM_PHASES];
  logic [CNT_W-1:0]   cur_last;
  logic               step;

  // Unpack the flat length bus; a zero length behaves as a one-cycle phase.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_PHASES; gi++) begin : g_len
      assign len_eff[gi] = (cfg_len[gi*CNT_W +: CNT_W] == '0) ?
                           CNT_W'(1) : cfg_len[gi*CNT_W +: CNT_W];
    end
  endgenerate

  // phase_cnt value on the final cycle of the current phase.
  always_comb begin
    cur_last = '0;
    for (int k = 0; k < NUM_PHASES; k++) begin
      if (state_q == STATE_W'(k + 1)) cur_last = len_q[k] - CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    iter_d  = iter_q;
    done_d  = 1'b0;
    upd_d   = 1'b0;
    iters_d = iters_q;
    len_d   = len_q;
    step    = 1'b0;

    if (state_q == IDLE) begin
      // iter_cnt keeps its final value in IDLE; abort (even in IDLE) masks start.
      pcnt_d = '0;
      if (start && !abort) begin
        state_d = FIRST;
        upd_d   = 1'b1;
        iter_d  = '0;
        len_d   = len_eff;
        iters_d = (cfg_iters == '0) ? ITER_W'(1) : cfg_iters;
      end
    end else if (state_q > LAST_PHASE || abort) begin
      // Illegal encoding or abort: back to IDLE quietly, no done.
      state_d = IDLE;
      upd_d   = 1'b1;
      pcnt_d  = '0;
      iter_d  = '0;
    end else begin
      if (pcnt_q != '1) pcnt_d = pcnt_q + CNT_W'(1);
      // A manual and an automatic step in the same cycle merge into one step.
      step = advance | (auto_en & (pcnt_q == cur_last));
      if (step) begin
        upd_d  = 1'b1;
        pcnt_d = '0;
        if (state_q != LAST_PHASE) begin
          state_d = state_q + STATE_W'(1);
        end else if (iter_q != iters_q - ITER_W'(1)) begin
          state_d = FIRST;
          iter_d  = iter_q + ITER_W'(1);
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      pcnt_q  <= '0;
      iter_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      upd_q   <= 1'b0;
      iters_q <= '0;
      for (int k = 0; k < NUM_PHASES; k++) len_q[k] <= '0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      iter_q  <= iter_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      upd_q   <= upd_d;
      iters_q <= iters_d;
      for (int k = 0; k < NUM_PHASES; k++) len_q[k] <= len_d[k];
    end
  end

  assign current_state = state_q;
  assign state_update  = upd_q;
  assign phase_cnt     = pcnt_q;
  assign iter_cnt      = iter_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule
